// File: rtl/shared_mem_pkg.sv
// Shared definitions for the dual-port Avalon-MM to single-port memory arbiter.
package shared_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 14;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned DEPTH_DEF  = 12500;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_t;

  typedef struct packed {
    logic  valid;
    port_t owner;
    logic  oor;
  } rd_stage_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter with one-hot grant; the pointer names the
// port that wins the next tie.
module rr_arbiter2
  import shared_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  port_t rr_ptr_q, rr_ptr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= PORT0;
    else     rr_ptr_q <= rr_ptr_d;
  end

  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (rr_ptr_q == PORT1) ? 2'b10 : 2'b01;
      default: grant = '0;
    endcase
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant[0])      rr_ptr_d = PORT1;
    else if (grant[1]) rr_ptr_d = PORT0;
  end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Arbitrates two Avalon-MM slave ports onto one pipelined single-port memory
// with a fixed two-cycle read latency and sticky out-of-range flags.
module shared_mem_arbiter
  import shared_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   s0_address,
  input  logic [DATA_W/8-1:0] s0_byteenable,
  input  logic                s0_read,
  input  logic                s0_write,
  input  logic [DATA_W-1:0]   s0_writedata,
  output logic                s0_waitrequest,
  output logic [DATA_W-1:0]   s0_readdata,
  output logic                s0_readdatavalid,
  output logic                s0_oor_err,
  input  logic [ADDR_W-1:0]   s1_address,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [DATA_W-1:0]   s1_writedata,
  output logic                s1_waitrequest,
  output logic [DATA_W-1:0]   s1_readdata,
  output logic                s1_readdatavalid,
  output logic                s1_oor_err,
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic                m_chipselect,
  output logic                m_write,
  output logic [DATA_W-1:0]   m_writedata,
  output logic                m_clken,
  input  logic [DATA_W-1:0]   m_readdata
);

  logic [1:0]          req, grant;
  logic                gnt_any, g_write, g_oor;
  port_t               gsel;
  logic [ADDR_W-1:0]   g_addr;
  logic [DATA_W/8-1:0] g_be;
  logic [DATA_W-1:0]   g_wdata;
  rd_stage_t           st1_q, st1_d, st2_q, st2_d;
  logic [DATA_W-1:0]   raw_q, raw_d, rsp_data;
  logic [DATA_W-1:0]   hold0_q, hold0_d, hold1_q, hold1_d;
  logic                oor0_q, oor0_d, oor1_q, oor1_d;

  assign req = reset ? 2'b00 : {s1_read | s1_write, s0_read | s0_write};

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst   (reset),
    .req   (req),
    .grant (grant)
  );

  always_comb begin
    gnt_any = |grant;
    gsel    = grant[1] ? PORT1 : PORT0;
    if (gsel == PORT1) begin
      g_addr = s1_address; g_be = s1_byteenable; g_wdata = s1_writedata; g_write = s1_write;
    end else begin
      g_addr = s0_address; g_be = s0_byteenable; g_wdata = s0_writedata; g_write = s0_write;
    end
    g_oor = gnt_any && (32'(g_addr) >= 32'(DEPTH));
  end

  assign m_address      = g_addr;
  assign m_byteenable   = g_be;
  assign m_writedata    = g_wdata;
  assign m_chipselect   = gnt_any & ~g_oor;
  assign m_write        = gnt_any & ~g_oor & g_write;
  assign m_clken        = 1'b1;
  assign s0_waitrequest = ~grant[0];
  assign s1_waitrequest = ~grant[1];

  // Raw memory data is captured one cycle after issue; out-of-range zeroing
  // and routing happen on the output side so the hold registers stay per port.
  always_comb begin
    st1_d    = '{valid: gnt_any & ~g_write, owner: gsel, oor: g_oor};
    st2_d    = st1_q;
    raw_d    = st1_q.valid ? m_readdata : raw_q;
    rsp_data = st2_q.oor ? '0 : raw_q;
    oor0_d   = oor0_q | (grant[0] & g_oor);
    oor1_d   = oor1_q | (grant[1] & g_oor);
  end

  assign s0_readdatavalid = st2_q.valid && (st2_q.owner == PORT0);
  assign s1_readdatavalid = st2_q.valid && (st2_q.owner == PORT1);
  assign s0_readdata      = s0_readdatavalid ? rsp_data : hold0_q;
  assign s1_readdata      = s1_readdatavalid ? rsp_data : hold1_q;
  assign s0_oor_err       = oor0_q;
  assign s1_oor_err       = oor1_q;

  always_comb begin
    hold0_d = s0_readdata;
    hold1_d = s1_readdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st1_q   <= '0;
      st2_q   <= '0;
      raw_q   <= '0;
      hold0_q <= '0;
      hold1_q <= '0;
      oor0_q  <= 1'b0;
      oor1_q  <= 1'b0;
    end else begin
      st1_q   <= st1_d;
      st2_q   <= st2_d;
      raw_q   <= raw_d;
      hold0_q <= hold0_d;
      hold1_q <= hold1_d;
      oor0_q  <= oor0_d;
      oor1_q  <= oor1_d;
    end
  end

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed and random checks of shared_mem_arbiter against a transaction-level
// model: expected grant, memory contents and a queue of due read responses.
module tb_shared_mem_arbiter;

  localparam int unsigned AW  = 14;
  localparam int unsigned DW  = 32;
  localparam int unsigned DEP = 12500;

  typedef struct packed {
    logic        r;
    logic        w;
    logic [13:0] a;
    logic [3:0]  be;
    logic [31:0] d;
  } req_t;

  typedef struct {
    int          due;
    int          port;
    logic [31:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic reset;
  logic [13:0] s0_address, s1_address, m_address;
  logic [3:0]  s0_byteenable, s1_byteenable, m_byteenable;
  logic        s0_read, s0_write, s1_read, s1_write;
  logic [31:0] s0_writedata, s1_writedata, s0_readdata, s1_readdata, m_writedata, m_readdata;
  logic        s0_waitrequest, s1_waitrequest, s0_readdatavalid, s1_readdatavalid;
  logic        s0_oor_err, s1_oor_err, m_chipselect, m_write, m_clken;

  always #5 clk = ~clk;

  shared_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP)) dut (
    .clk(clk), .reset(reset),
    .s0_address(s0_address), .s0_byteenable(s0_byteenable), .s0_read(s0_read),
    .s0_write(s0_write), .s0_writedata(s0_writedata), .s0_waitrequest(s0_waitrequest),
    .s0_readdata(s0_readdata), .s0_readdatavalid(s0_readdatavalid), .s0_oor_err(s0_oor_err),
    .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_read(s1_read),
    .s1_write(s1_write), .s1_writedata(s1_writedata), .s1_waitrequest(s1_waitrequest),
    .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid), .s1_oor_err(s1_oor_err),
    .m_address(m_address), .m_byteenable(m_byteenable), .m_chipselect(m_chipselect),
    .m_write(m_write), .m_writedata(m_writedata), .m_clken(m_clken), .m_readdata(m_readdata)
  );

  // Single-port RAM: registered address, unregistered q.
  logic [31:0] ram [0:DEP-1];
  logic [31:0] q = '0;
  assign m_readdata = q;
  always @(posedge clk) begin
    if (m_chipselect && (32'(m_address) < DEP)) begin
      if (m_write) begin
        for (int b = 0; b < 4; b++)
          if (m_byteenable[b]) ram[m_address][8*b +: 8] <= m_writedata[8*b +: 8];
      end else begin
        q <= ram[m_address];
      end
    end
  end

  logic [31:0] ref_mem [0:DEP-1];
  rsp_t        rspq[$];
  logic [31:0] last [2];
  logic        exp_oor [2];
  int          ptr, cyc;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic req_t idle();
    return '0;
  endfunction

  function automatic req_t rd(input logic [13:0] a);
    req_t r = '0;
    r.r = 1'b1; r.a = a; r.be = 4'hF;
    return r;
  endfunction

  function automatic req_t wr(input logic [13:0] a, input logic [3:0] be, input logic [31:0] d);
    req_t r = '0;
    r.w = 1'b1; r.a = a; r.be = be; r.d = d;
    return r;
  endfunction

  function automatic req_t rnd_req();
    req_t r;
    int k = $urandom_range(0, 9);
    r.r  = (k <= 3);
    r.w  = (k >= 3) && (k <= 6);
    r.a  = ($urandom_range(0, 19) == 0) ? 14'(12496 + $urandom_range(0, 7))
                                        : 14'($urandom_range(0, 15));
    r.be = 4'($urandom_range(0, 15));
    r.d  = $urandom;
    return r;
  endfunction

  task automatic drive(input req_t p0, input req_t p1);
    s0_read = p0.r; s0_write = p0.w; s0_address = p0.a; s0_byteenable = p0.be; s0_writedata = p0.d;
    s1_read = p1.r; s1_write = p1.w; s1_address = p1.a; s1_byteenable = p1.be; s1_writedata = p1.d;
  endtask

  task automatic step(input req_t p0, input req_t p1);
    req_t p [2];
    int   g;
    logic oor;
    logic v [2];
    p[0] = p0; p[1] = p1;
    drive(p0, p1);
    @(negedge clk);
    g = -1;
    oor = 1'b0;
    if ((p0.r | p0.w) && (p1.r | p1.w)) g = ptr;
    else if (p0.r | p0.w)               g = 0;
    else if (p1.r | p1.w)               g = 1;
    chk("wait0", 32'(s0_waitrequest), 32'(g != 0));
    chk("wait1", 32'(s1_waitrequest), 32'(g != 1));
    if (g >= 0) begin
      oor = (32'(p[g].a) >= DEP);
      chk("m_cs", 32'(m_chipselect), 32'(!oor));
      chk("m_write", 32'(m_write), 32'(p[g].w && !oor));
      chk("m_addr", 32'(m_address), 32'(p[g].a));
      if (p[g].w && !oor) begin
        chk("m_be", 32'(m_byteenable), 32'(p[g].be));
        chk("m_wdata", m_writedata, p[g].d);
      end
    end else begin
      chk("m_cs_idle", 32'(m_chipselect), 32'd0);
      chk("m_write_idle", 32'(m_write), 32'd0);
    end
    chk("m_clken", 32'(m_clken), 32'd1);
    v[0] = 1'b0; v[1] = 1'b0;
    if (rspq.size() > 0 && rspq[0].due == cyc) begin
      v[rspq[0].port]    = 1'b1;
      last[rspq[0].port] = rspq[0].data;
      void'(rspq.pop_front());
    end
    chk("rdv0", 32'(s0_readdatavalid), 32'(v[0]));
    chk("rdv1", 32'(s1_readdatavalid), 32'(v[1]));
    chk("rdata0", s0_readdata, last[0]);
    chk("rdata1", s1_readdata, last[1]);
    chk("oor0", 32'(s0_oor_err), 32'(exp_oor[0]));
    chk("oor1", 32'(s1_oor_err), 32'(exp_oor[1]));
    if (g >= 0) begin
      if (p[g].w) begin
        if (!oor)
          for (int b = 0; b < 4; b++)
            if (p[g].be[b]) ref_mem[p[g].a][8*b +: 8] = p[g].d[8*b +: 8];
      end else begin
        rspq.push_back('{due: cyc + 2, port: g, data: oor ? 32'd0 : ref_mem[p[g].a]});
      end
      if (oor) exp_oor[g] = 1'b1;
      ptr = 1 - g;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(rd(14'h0003), wr(14'h0004, 4'hF, 32'h5555AAAA));
    reset = 1'b1;
    #1;
    chk("rst_wait0", 32'(s0_waitrequest), 32'd1);
    chk("rst_wait1", 32'(s1_waitrequest), 32'd1);
    chk("rst_cs", 32'(m_chipselect), 32'd0);
    chk("rst_write", 32'(m_write), 32'd0);
    chk("rst_rdata0", s0_readdata, 32'd0);
    chk("rst_rdata1", s1_readdata, 32'd0);
    chk("rst_oor0", 32'(s0_oor_err), 32'd0);
    chk("rst_oor1", 32'(s1_oor_err), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("rst_rdv0", 32'(s0_readdatavalid), 32'd0);
      chk("rst_rdv1", 32'(s1_readdatavalid), 32'd0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    rspq.delete();
    ptr = 0;
    last[0] = '0; last[1] = '0;
    exp_oor[0] = 1'b0; exp_oor[1] = 1'b0;
    drive(idle(), idle());
  endtask

  initial begin
    cyc = 0;
    ptr = 0;
    for (int i = 0; i < int'(DEP); i++) begin
      ram[i]     = '0;
      ref_mem[i] = '0;
    end
    do_reset();

    // Write then read back on port 0.
    step(wr(14'h0010, 4'hF, 32'hDEADBEEF), idle());
    step(rd(14'h0010), idle());
    repeat (3) step(idle(), idle());
    chk("req030_data", s0_readdata, 32'hDEADBEEF);

    // Both ports contend continuously right after reset.
    do_reset();
    for (int i = 0; i < 6; i++) step(rd(14'(i)), rd(14'(16 + i)));
    repeat (3) step(idle(), idle());

    // Partial-byte overwrite from port 1.
    step(idle(), wr(14'h0020, 4'hF, 32'h11223344));
    step(idle(), wr(14'h0020, 4'h3, 32'hAABBCCDD));
    step(idle(), rd(14'h0020));
    repeat (3) step(idle(), idle());
    chk("req032_data", s1_readdata, 32'h1122CCDD);

    // Out-of-range accesses from port 0.
    step(wr(14'h0005, 4'hF, 32'hCAFEF00D), idle());
    step(rd(14'h30D4), idle());
    step(wr(14'h30D5, 4'hF, 32'h12345678), idle());
    repeat (3) step(idle(), idle());
    chk("req033_data", s0_readdata, 32'd0);
    chk("req033_oor0", 32'(s0_oor_err), 32'd1);
    chk("req033_oor1", 32'(s1_oor_err), 32'd0);

    // Back-to-back alternating reads.
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) step(rd(14'(1 + i)), idle());
      else            step(idle(), rd(14'(1 + i)));
    end
    repeat (3) step(idle(), idle());

    // Reset lands while a read is in flight.
    step(rd(14'h0010), idle());
    do_reset();
    step(rd(14'h0010), rd(14'h0020));
    repeat (3) step(idle(), idle());

    for (int i = 0; i < 400; i++) step(rnd_req(), rnd_req());
    repeat (3) step(idle(), idle());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shared_mem_arbiter.md
SHARED_MEM_ARBITER -- requirements
Module: shared_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 14, word-address width of the on-chip memory port.
REQ-002 Parameter DATA_W, default 32, data width; byteenable width is DATA_W/8.
REQ-003 Parameter DEPTH, default 12500, number of implemented memory words.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 sN_address / sN_byteenable / sN_read / sN_write / sN_writedata  in  14/4/1/1/32  Avalon-MM slave request from processor N, N = 0,1.
REQ-007 sN_waitrequest  out  1  high = request of port N not accepted this cycle.
REQ-008 sN_readdata / sN_readdatavalid  out  32/1  read response to port N.
REQ-009 sN_oor_err  out  1  sticky: port N issued an access with address >= DEPTH.
REQ-010 m_address / m_byteenable / m_chipselect / m_write / m_writedata / m_clken  out  14/4/1/1/32/1  drive of the single-port memory.
REQ-011 m_readdata  in  32  memory output, valid the cycle after the address is presented (unregistered q).

Function
REQ-012 At most one request is forwarded to the memory per cycle; the memory may accept a new request every cycle (fully pipelined).
REQ-013 Port N requests when sN_read or sN_write is high; sN_read and sN_write both high is treated as a write only.
REQ-014 One requester: it is granted that cycle; both requesting: the port named by the round-robin pointer rr_ptr is granted.
REQ-015 After any grant, rr_ptr is set to the non-granted port; with no grant rr_ptr holds.
REQ-016 sN_waitrequest is low exactly in the cycle port N is granted; it is high when port N is idle or loses arbitration (combinational, same cycle).
REQ-017 Granted cycle: m_chipselect = 1, m_address/m_byteenable/m_writedata = granted port's signals, m_write = granted write; no grant: m_chipselect = 0, m_write = 0.
REQ-018 Granted address >= DEPTH: m_chipselect and m_write are forced 0 (write dropped), sN_oor_err set, transaction still completes.
REQ-019 Read accepted in cycle T: m_readdata is captured at the end of T+1; sN_readdata/sN_readdatavalid are registered and asserted for exactly cycle T+2 (fixed latency 2).
REQ-020 Out-of-range read returns sN_readdata = 0 with normal latency 2.
REQ-021 Read pipeline is two stages (valid bit + owner tag + oor bit each); back-to-back reads from either port return in issue order, one per cycle.
REQ-022 sN_readdata holds its last value when sN_readdatavalid is low.
REQ-023 Writes produce no response; write accepted in T is visible to a read accepted in T+1 or later.
REQ-024 m_clken is constant 1.

Reset
REQ-025 On reset assertion, immediately: rr_ptr = 0, both pipeline valid bits = 0, sN_readdatavalid = 0, sN_readdata = 0, sN_oor_err = 0.
REQ-026 Reads in flight at reset never produce sN_readdatavalid.
REQ-027 While reset is high, m_chipselect = 0, m_write = 0, sN_waitrequest = 1.

Structure
REQ-028 Package shared_mem_pkg holds ADDR_W/DATA_W/DEPTH defaults, the port-index type and the read-pipeline stage struct (valid, owner, oor).
REQ-029 Sub-module rr_arbiter2 (two-requester round-robin: req[1:0], rr_ptr register, one-hot grant) is instantiated once; the mux and read pipeline stay in the top.

Verification
REQ-030 Port 0 writes 0xDEADBEEF to 0x0010, byteenable 0xF, then reads 0x0010 -> s0_readdatavalid exactly 2 cycles after the read grant, s0_readdata = 0xDEADBEEF.
REQ-031 Both ports request continuously for 6 cycles after reset -> grants alternate 0,1,0,1,0,1; each loser sees waitrequest = 1.
REQ-032 Port 1 writes 0x11223344 then 0xAABBCCDD to 0x0020 with byteenable 0x3 -> read returns 0x1122CCDD.
REQ-033 Port 0 reads 12500 (0x30D4) and writes 0x30D5 -> read returns 0, memory unchanged, s0_oor_err = 1, s1_oor_err = 0.
REQ-034 Alternating reads from ports 0/1 to 0x0001..0x0004 back-to-back -> four responses, one per cycle, routed to the issuing port in order.
REQ-035 Reset asserted the cycle after a read grant -> no readdatavalid on either port; first post-reset simultaneous request is granted to port 0.
